// File: rtl/ysyx_25030077_pkg.sv
// Shared types and constants for the ysyx_25030077 instruction fetch unit.
package ysyx_25030077_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef enum logic [2:0] {
      IFU_BOOT,
      IFU_REQ,
      IFU_WAIT,
      IFU_DELIV,
      IFU_HALT,
      IFU_FAULT
   } ifu_state_e;

endpackage

// File: rtl/ysyx_25030077_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time, presents the
// fetched word to execute and closes the PC loop with the next-PC unit.
//
//   state  | meaning
//   BOOT   | one idle cycle after reset, no handshakes
//   REQ    | fetch request at pc held until accepted
//   WAIT   | request accepted, waiting for the response pulse
//   DELIV  | instruction + pc presented until consumed
//   HALT   | ebreak retired, terminal until reset
//   FAULT  | fetch error, misaligned target or unknown instruction, terminal
module ysyx_25030077_ifu
   import ysyx_25030077_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clock,
   input  logic            reset,
   output logic            io_imem_req_valid,
   input  logic            io_imem_req_ready,
   output logic [XLEN-1:0] io_imem_req_addr,
   input  logic            io_imem_resp_valid,
   input  logic [XLEN-1:0] io_imem_resp_data,
   input  logic            io_imem_resp_err,
   output logic            io_inst_valid,
   input  logic            io_inst_ready,
   output logic [XLEN-1:0] io_instruction,
   output logic [XLEN-1:0] io_pc_count,
   input  logic [XLEN-1:0] io_pc_next,
   input  logic            io_is_unknown_instruction,
   input  logic            io_halt,
   output logic            io_fault,
   output logic            io_halted,
   output logic [XLEN-1:0] io_retired
);

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] retired_q, retired_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      retired_d = retired_q;
      unique case (state_q)
         IFU_BOOT: state_d = IFU_REQ;
         IFU_REQ: begin
            if (io_imem_req_ready) state_d = IFU_WAIT;
         end
         IFU_WAIT: begin
            if (io_imem_resp_valid) begin
               if (io_imem_resp_err) begin
                  state_d = IFU_FAULT;
               end else begin
                  inst_d  = io_imem_resp_data;
                  state_d = IFU_DELIV;
               end
            end
         end
         IFU_DELIV: begin
            // The consuming instruction counts as retired even when it ends the run.
            if (io_inst_ready) begin
               retired_d = retired_q + 32'd1;
               if (io_is_unknown_instruction) begin
                  state_d = IFU_FAULT;
               end else if (io_halt) begin
                  pc_d    = io_pc_next;
                  state_d = IFU_HALT;
               end else if (io_pc_next[1:0] != 2'b00) begin
                  state_d = IFU_FAULT;
               end else begin
                  pc_d    = io_pc_next;
                  state_d = IFU_REQ;
               end
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IFU_BOOT;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         retired_q <= retired_d;
      end
   end

   assign io_imem_req_valid = (state_q == IFU_REQ);
   assign io_imem_req_addr  = pc_q;
   assign io_inst_valid     = (state_q == IFU_DELIV);
   assign io_instruction    = inst_q;
   assign io_pc_count       = pc_q;
   assign io_fault          = (state_q == IFU_FAULT);
   assign io_halted         = (state_q == IFU_HALT);
   assign io_retired        = retired_q;

endmodule

// File: tb/tb_ysyx_25030077_ifu.sv
// Bench for the fetch unit: a memory model, a next-PC driver and a reference
// model of the architectural fetch/retire behaviour, all sampled on the falling edge.
module tb_ysyx_25030077_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int T_RUN = 0, T_HALT = 1, T_FAULT = 2;

   typedef struct {
      logic        unk;
      logic        halt;
      logic [31:0] nxt;
   } act_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        io_imem_req_valid;
   logic        io_imem_req_ready = 1'b0;
   logic [31:0] io_imem_req_addr;
   logic        io_imem_resp_valid = 1'b0;
   logic [31:0] io_imem_resp_data = '0;
   logic        io_imem_resp_err = 1'b0;
   logic        io_inst_valid;
   logic        io_inst_ready = 1'b0;
   logic [31:0] io_instruction;
   logic [31:0] io_pc_count;
   logic [31:0] io_pc_next = '0;
   logic        io_is_unknown_instruction = 1'b0;
   logic        io_halt = 1'b0;
   logic        io_fault;
   logic        io_halted;
   logic [31:0] io_retired;

   ysyx_25030077_ifu dut (
      .clock(clock), .reset(reset),
      .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
      .io_imem_req_addr(io_imem_req_addr), .io_imem_resp_valid(io_imem_resp_valid),
      .io_imem_resp_data(io_imem_resp_data), .io_imem_resp_err(io_imem_resp_err),
      .io_inst_valid(io_inst_valid), .io_inst_ready(io_inst_ready),
      .io_instruction(io_instruction), .io_pc_count(io_pc_count),
      .io_pc_next(io_pc_next), .io_is_unknown_instruction(io_is_unknown_instruction),
      .io_halt(io_halt), .io_fault(io_fault), .io_halted(io_halted),
      .io_retired(io_retired)
   );

   always #5 clock = ~clock;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr * 32'h9E37_79B1 ^ 32'h0000_0013;
   endfunction

   // knobs written only by the main sequence
   bit   ready_always = 1, cons_always = 1, hold_ready = 0, gen_en = 0, spur_en = 0;
   bit   err_en = 0;
   logic [31:0] err_addr = '0;
   int   err_pct = 0, lat_min = 1, lat_max = 1, period_chk = 0, preload_seq = 0;
   act_t plan[$];

   // reference model and memory state, written only by the sampling process
   logic [31:0] exp_pc = RST_PC, exp_retired = '0, exp_inst = '0;
   int   exp_term = T_RUN;
   bit   exp_deliv = 0;
   int   lat_cnt = 0, acc_count = 0, cons_count = 0, preload_seen = 0;
   bit   poison = 0, pend_err = 0, have_last = 0;
   logic [31:0] pend_data = '0;
   int   cyc = 0, last_cons = 0;

   function automatic act_t gen_act(input logic [31:0] pc);
      act_t a;
      int r;
      logic [13:0] off;
      r      = $urandom_range(0, 99);
      off    = 14'($urandom);
      a.unk  = 1'b0;
      a.halt = 1'b0;
      a.nxt  = (r % 2 == 0) ? pc + 32'd4 : {16'h8000, off, 2'b00};
      if (r < 3) begin
         a.unk  = 1'b1;
         a.halt = 1'($urandom);
         a.nxt  = $urandom;
      end else if (r < 6) begin
         a.halt = 1'b1;
      end else if (r < 10) begin
         a.nxt[1:0] = 2'($urandom_range(1, 3));
      end
      return a;
   endfunction

   always @(negedge clock) begin
      act_t a;
      cyc++;
      if (!reset) begin
         if (lat_cnt != 0) poison = 1;
         exp_pc = RST_PC; exp_retired = '0; exp_inst = '0; exp_term = T_RUN;
         exp_deliv = 0; acc_count = 0; have_last = 0;
      end
      if (preload_seq != preload_seen) begin
         exp_retired  = 32'hFFFF_FFFF;
         preload_seen = preload_seq;
      end
      if (reset) begin
         check_val("pc", io_pc_count, exp_pc);
         check_val("retired", io_retired, exp_retired);
         check_val("instruction", io_instruction, exp_inst);
         check_val("inst_valid", io_inst_valid, exp_deliv);
         check_val("fault", io_fault, exp_term == T_FAULT);
         check_val("halted", io_halted, exp_term == T_HALT);
         if (io_imem_req_valid) check_val("req_addr", io_imem_req_addr, exp_pc);
         if (exp_term != T_RUN) check_val("term_req_valid", io_imem_req_valid, 0);
      end
      io_imem_resp_valid = 0; io_imem_resp_err = 0; io_imem_resp_data = $urandom;
      io_imem_req_ready = 0;
      io_inst_ready = 0; io_pc_next = $urandom;
      io_is_unknown_instruction = 1'($urandom); io_halt = 1'($urandom);
      if (lat_cnt != 0) begin
         lat_cnt--;
         if (lat_cnt == 0) begin
            io_imem_resp_valid = 1;
            if (poison) begin
               io_imem_resp_data = 32'hBAD0_BAD0;
               poison = 0;
            end else begin
               io_imem_resp_data = pend_data;
               io_imem_resp_err  = pend_err;
               if (reset) begin
                  if (pend_err) exp_term = T_FAULT;
                  else begin exp_inst = pend_data; exp_deliv = 1; end
               end
            end
         end
      end else if (spur_en && reset && $urandom_range(0, 7) == 0) begin
         // stray response outside WAIT must be ignored
         io_imem_resp_valid = 1;
         io_imem_resp_err   = 1'($urandom);
      end
      if (reset && lat_cnt == 0 && !hold_ready && (ready_always || $urandom_range(0, 2) != 0)) begin
         io_imem_req_ready = 1;
         if (io_imem_req_valid) begin
            acc_count++;
            lat_cnt   = $urandom_range(lat_max, lat_min);
            pend_data = mem_word(io_imem_req_addr);
            pend_err  = (err_en && io_imem_req_addr == err_addr) || ($urandom_range(0, 99) < err_pct);
         end
      end
      if (reset && io_inst_valid && (cons_always || $urandom_range(0, 2) != 0)
          && (plan.size() != 0 || gen_en)) begin
         a = (plan.size() != 0) ? plan.pop_front() : gen_act(exp_pc);
         io_inst_ready = 1;
         io_is_unknown_instruction = a.unk;
         io_halt = a.halt;
         io_pc_next = a.nxt;
         exp_retired = exp_retired + 32'd1;
         exp_deliv = 0;
         if (a.unk) exp_term = T_FAULT;
         else if (a.halt) begin exp_pc = a.nxt; exp_term = T_HALT; end
         else if (a.nxt[1:0] != 2'b00) exp_term = T_FAULT;
         else exp_pc = a.nxt;
         if (period_chk != 0 && have_last) check_val("consume_period", cyc - last_cons, 3);
         have_last = 1;
         last_cons = cyc;
         cons_count++;
      end
   end

   task automatic apply_reset();
      @(negedge clock); #2;
      reset = 0;
      #1;
      check_val("rst_req_valid", io_imem_req_valid, 0);
      check_val("rst_inst_valid", io_inst_valid, 0);
      check_val("rst_req_addr", io_imem_req_addr, RST_PC);
      check_val("rst_pc", io_pc_count, RST_PC);
      check_val("rst_instruction", io_instruction, 0);
      check_val("rst_fault", io_fault, 0);
      check_val("rst_halted", io_halted, 0);
      check_val("rst_retired", io_retired, 0);
      @(negedge clock); #2;
      reset = 1;
   endtask

   task automatic wait_cons(input int n, input int budget);
      int target, t;
      target = cons_count + n;
      t = 0;
      while (cons_count < target && t < budget) begin
         @(negedge clock); t++;
      end
      #1;
      if (cons_count < target) check_val("wait_timeout", cons_count, target);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   function automatic act_t mk(input logic unk, input logic halt, input logic [31:0] nxt);
      act_t a;
      a.unk = unk; a.halt = halt; a.nxt = nxt;
      return a;
   endfunction

   initial begin
      int acc_snap, t;
      // straight-line fetch loop, 3 cycles per instruction
      apply_reset();
      period_chk = 1;
      plan.push_back(mk(0, 0, 32'h8000_0004));
      plan.push_back(mk(0, 0, 32'h8000_0008));
      plan.push_back(mk(0, 0, 32'h8000_000C));
      plan.push_back(mk(0, 0, 32'h8000_0010));
      wait_cons(4, 40);
      idle(2);
      check_val("loop_pc", io_pc_count, 32'h8000_0010);
      check_val("loop_retired", io_retired, 4);
      period_chk = 0;

      // request held while memory is not ready
      apply_reset();
      hold_ready = 1;
      idle(1);
      repeat (5) begin
         check_val("hold_req_valid", io_imem_req_valid, 1);
         check_val("hold_req_addr", io_imem_req_addr, RST_PC);
         idle(1);
      end
      check_val("hold_no_accept", acc_count, 0);
      hold_ready = 0;
      plan.push_back(mk(0, 0, 32'h8000_0004));
      wait_cons(1, 40);

      // fetch error on the first request
      apply_reset();
      err_en = 1; err_addr = RST_PC;
      idle(10);
      check_val("err_fault", io_fault, 1);
      check_val("err_accepts", acc_count, 1);
      check_val("err_retired", io_retired, 0);
      err_en = 0;

      // misaligned target
      apply_reset();
      plan.push_back(mk(0, 0, 32'h8000_0004));
      plan.push_back(mk(0, 0, 32'h8000_0102));
      wait_cons(2, 40);
      idle(3);
      check_val("mis_fault", io_fault, 1);
      check_val("mis_pc", io_pc_count, 32'h8000_0004);
      check_val("mis_retired", io_retired, 2);

      // unknown instruction wins over halt
      apply_reset();
      plan.push_back(mk(1, 1, 32'h8000_0020));
      wait_cons(1, 40);
      idle(3);
      check_val("unk_fault", io_fault, 1);
      check_val("unk_halted", io_halted, 0);
      check_val("unk_pc", io_pc_count, RST_PC);

      // halt
      apply_reset();
      plan.push_back(mk(0, 1, 32'h8000_0010));
      wait_cons(1, 40);
      idle(1);
      acc_snap = acc_count;
      idle(6);
      check_val("halt_halted", io_halted, 1);
      check_val("halt_pc", io_pc_count, 32'h8000_0010);
      check_val("halt_no_req", acc_count, acc_snap);

      // reset while a request is outstanding; the late response must be dropped
      apply_reset();
      lat_min = 4; lat_max = 4;
      t = 0;
      while (lat_cnt == 0 && t < 20) begin @(negedge clock); t++; end
      #1;
      check_val("wait_entered", lat_cnt != 0, 1);
      apply_reset();
      lat_min = 1; lat_max = 1;
      plan.push_back(mk(0, 0, 32'h8000_0004));
      wait_cons(1, 40);
      idle(1);
      check_val("late_resp_word", io_retired, 1);

      // retire counter wraps
      apply_reset();
      hold_ready = 1;
      idle(1);
      force dut.retired_q = 32'hFFFF_FFFF;
      preload_seq++;
      idle(2);
      release dut.retired_q;
      hold_ready = 0;
      plan.push_back(mk(0, 0, 32'h8000_0004));
      wait_cons(1, 40);
      idle(1);
      check_val("retired_wrap", io_retired, 0);

      // randomized episodes against the reference model
      gen_en = 1; cons_always = 0; ready_always = 0; spur_en = 1;
      lat_min = 1; lat_max = 3; err_pct = 2;
      for (int ep = 0; ep < 25; ep++) begin
         apply_reset();
         t = 0;
         while (exp_term == T_RUN && t < 400) begin @(negedge clock); t++; end
         idle(5);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_25030077_ifu.md
# ysyx_25030077_ifu

Instruction fetch unit of the ysyx_25030077 NPC core: owns the architectural PC register, issues single-outstanding fetch requests to instruction memory, and presents the fetched word with its PC to decode/execute. It consumes the next-PC value computed by the next-PC unit, together with that unit's unknown-instruction flag, closing the PC loop. It also latches fetch faults and the halt (ebreak) condition.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_imem_req_valid  out  1  fetch request valid
- io_imem_req_ready  in  1  memory accepts request
- io_imem_req_addr  out  32  fetch address (= PC)
- io_imem_resp_valid  in  1  response valid (one-cycle pulse, no backpressure)
- io_imem_resp_data  in  32  fetched instruction word
- io_imem_resp_err  in  1  access error, qualified by resp_valid
- io_inst_valid  out  1  instruction/PC presented to execute
- io_inst_ready  in  1  execute consumes instruction this cycle
- io_instruction  out  32  registered fetched word
- io_pc_count  out  32  current PC
- io_pc_next  in  32  next PC from next-PC unit, sampled on consume
- io_is_unknown_instruction  in  1  from next-PC unit, sampled on consume
- io_halt  in  1  ebreak retired, sampled on consume
- io_fault  out  1  sticky: bad fetch, misaligned target, or unknown instruction
- io_halted  out  1  sticky: halt taken
- io_retired  out  32  count of consumed instructions

## Operation
- States: BOOT, REQ, WAIT, DELIV, HALT, FAULT.
- BOOT: entered on reset; next cycle -> REQ. All handshake outputs low.
- REQ: req_valid=1, req_addr=pc. Addr and valid hold stable until req_ready; on req_valid&req_ready -> WAIT.
- WAIT: on resp_valid: resp_err=1 -> FAULT; else latch resp_data into instruction register -> DELIV. resp_valid in any other state is ignored.
- DELIV: inst_valid=1. On inst_valid&inst_ready ("consume"): retired += 1 (wraps at 2^32); priority: is_unknown_instruction -> FAULT (pc unchanged); else halt -> HALT (pc <= pc_next); else pc_next[1:0]!=0 -> FAULT (pc unchanged); else pc <= pc_next, -> REQ.
- HALT / FAULT: terminal until reset; all valids low; io_halted / io_fault =1.
- pc_next is used verbatim; the block adds no offsets.

## Timing
- Reset values: req_valid 0, inst_valid 0, req_addr = pc_count = RESET_PC, instruction 0, fault 0, halted 0, retired 0, state BOOT.
- Reset asserts asynchronously mid-operation (any state, including an accepted-but-unanswered request): immediate return to reset values; a late response after release is ignored (arrives outside WAIT or before a new request).
- Minimum per-instruction loop with ready=1 and 1-cycle memory: REQ(1) + WAIT(1) + DELIV(1) = 3 cycles.
- inst_valid rises the cycle after resp_valid; instruction, pc_count stable throughout DELIV.
- New PC is visible on io_pc_count/req_addr the cycle after consume.
- req_ready held low: stay in REQ indefinitely, outputs stable.
- retired updates the cycle after consume, including the consuming halt/fault instruction.

## Structure
- Package ysyx_25030077_pkg: ifu state enum, RESET_PC default, width constant XLEN=32.
- Single flat module; no sub-module warranted (FSM, PC register, instruction register, retire counter).

## Test plan
- Reset release, mem ready=1, 1-cycle latency, resp 0x00000013, pc_next=0x80000004 -> req_addr 0x80000000 then 0x80000004; inst_valid high 1 cycle per 3; retired=1 after first consume.
- req_ready low for 5 cycles -> req_valid, req_addr 0x80000000 held constant; WAIT entered only on ready.
- resp_err=1 on first fetch -> io_fault=1, inst_valid never asserted, no further requests, retired=0.
- Consume with pc_next=0x80000102 -> io_fault=1, pc_count stays at faulting PC; with is_unknown_instruction=1 -> io_fault=1, pc unchanged.
- Consume with io_halt=1, pc_next=0x80000010 -> io_halted=1, pc_count=0x80000010, no request issued afterward.
- Reset asserted in WAIT, response pulse arrives 1 cycle after release -> ignored; first delivered word comes from the fresh fetch at 0x80000000; preload retired 0xFFFFFFFF via long run or force -> wraps to 0.
